// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file.
// No logic of its own; the state enum and depth helper are used by the top and the init sequencer.
// No flow control at this level.
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_INIT,
        RF_READY
    } rfState_t;

    // Number of registers addressed by an addrW-bit address.
    function automatic int depthOf(input int addrW);
        return 1 << addrW;
    endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Init sequencer: walks every register once after reset or on init_req, emitting one write per cycle.
// Sweep takes exactly DEPTH cycles; busy is high for the whole sweep.
// No backpressure: the sweep cannot be stalled, and init_req is ignored while a sweep is running.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int INIT_MODE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init_req,
    output logic              busy,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data
);

    localparam int DEPTH = depthOf(ADDR_W);
    // One spare bit so the counter never wraps back onto reg 0.
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    rfState_t        state;
    rfState_t        stateNext;
    logic [ADDR_W:0] cnt;
    logic [ADDR_W:0] cntNext;

    // State and sweep counter; reset restarts the sweep from reg 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RF_INIT;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next-state, counter advance and sweep write outputs.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        busy      = 1'b0;
        init_we   = 1'b0;
        init_addr = cnt[ADDR_W-1:0];
        init_data = '0;
        case (state)
            RF_INIT: begin
                busy    = 1'b1;
                init_we = 1'b1;
                if (INIT_MODE != 0) begin
                    init_data = DATA_W'(cnt[ADDR_W-1:0]);
                end
                if (cnt == LAST) begin
                    stateNext = RF_READY;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + ONE;
                end
            end
            RF_READY: begin
                if (init_req) begin
                    stateNext = RF_INIT;
                    cntNext   = '0;
                end
            end
            default: begin
                stateNext = RF_INIT;
                cntNext   = '0;
            end
        endcase
    end

endmodule

// File: rtl/regfile_param.sv
// 2-read/1-write register file with optional write->read bypass and hardwired zero register.
// Reads have 1-cycle latency; writes land at the clock edge.
// No backpressure; while busy (init sweep) port writes are dropped and read data is forced to 0.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    parameter int INIT_MODE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init_req,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic              regWrite,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              busy
);

    localparam int DEPTH = depthOf(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              initWe;
    logic [ADDR_W-1:0] initAddr;
    logic [DATA_W-1:0] initData;
    logic              portWe;
    logic [DATA_W-1:0] rdVal1;
    logic [DATA_W-1:0] rdVal2;

    regfile_init_seq #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_MODE (INIT_MODE)
    ) u_init_seq (
        .clock     (clock),
        .reset     (reset),
        .init_req  (init_req),
        .busy      (busy),
        .init_we   (initWe),
        .init_addr (initAddr),
        .init_data (initData)
    );

    // Port write is qualified by READY and by the zero-register drop.
    always_comb begin
        portWe = regWrite && !busy && !((ZERO_REG != 0) && (writeReg == '0));
    end

    // Storage: sweep writes own the array while busy, otherwise the port write.
    always_ff @(posedge clock) begin
        if (initWe) begin
            mem[initAddr] <= initData;
        end else if (portWe) begin
            mem[writeReg] <= writeData;
        end
    end

    // Read-port value selection: zero register, then bypass, then array.
    always_comb begin
        rdVal1 = mem[readReg1];
        rdVal2 = mem[readReg2];
        if ((BYPASS != 0) && portWe && (writeReg == readReg1)) begin
            rdVal1 = writeData;
        end
        if ((BYPASS != 0) && portWe && (writeReg == readReg2)) begin
            rdVal2 = writeData;
        end
        if ((ZERO_REG != 0) && (readReg1 == '0)) begin
            rdVal1 = '0;
        end
        if ((ZERO_REG != 0) && (readReg2 == '0)) begin
            rdVal2 = '0;
        end
    end

    // Registered read data, cleared by reset and held at 0 during the sweep.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readData1 <= '0;
            readData2 <= '0;
        end else if (busy) begin
            readData1 <= '0;
            readData2 <= '0;
        end else begin
            readData1 <= rdVal1;
            readData2 <= rdVal2;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: two instances (zero-reg+bypass, and plain read-before-write).
// Expected outputs are pushed per cycle and checked one cycle later on the falling edge.
// No flow control in the design; the monitor checks every scheduled cycle.
module tb_regfile_param;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        init_req = 1'b0;
    logic [4:0]  readReg1 = '0;
    logic [4:0]  readReg2 = '0;
    logic [4:0]  writeReg = '0;
    logic [31:0] writeData = '0;
    logic        regWrite = 1'b0;

    logic [31:0] rdA1, rdA2, rdB1, rdB2;
    logic        busyA, busyB;

    typedef struct {
        int          due;
        logic        expBusy;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] b1;
        logic [31:0] b2;
    } exp_t;

    exp_t  expQ[$];
    string nameQ[$];
    int    cyc = 0;
    int    nTests = 0;
    int    nFail = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    regfile_param #(
        .DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1), .INIT_MODE(1)
    ) dutA (
        .clock(clock), .reset(reset), .init_req(init_req),
        .readReg1(readReg1), .readReg2(readReg2), .writeReg(writeReg),
        .writeData(writeData), .regWrite(regWrite),
        .readData1(rdA1), .readData2(rdA2), .busy(busyA)
    );

    regfile_param #(
        .DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0), .INIT_MODE(1)
    ) dutB (
        .clock(clock), .reset(reset), .init_req(init_req),
        .readReg1(readReg1), .readReg2(readReg2), .writeReg(writeReg),
        .writeData(writeData), .regWrite(regWrite),
        .readData1(rdB1), .readData2(rdB2), .busy(busyB)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare every expectation that falls due on this cycle.
    always @(negedge clock) begin
        exp_t  e;
        string n;
        while (expQ.size() > 0 && expQ[0].due <= cyc) begin
            e = expQ.pop_front();
            n = nameQ.pop_front();
            if (e.due < cyc) begin
                nTests++;
                nFail++;
                $display("FAIL %s: expectation stale, due cycle %0d, now %0d", n, e.due, cyc);
            end else begin
                chk({n, ".busyA"}, {31'b0, busyA}, {31'b0, e.expBusy});
                chk({n, ".busyB"}, {31'b0, busyB}, {31'b0, e.expBusy});
                chk({n, ".A1"}, rdA1, e.a1);
                chk({n, ".A2"}, rdA2, e.a2);
                chk({n, ".B1"}, rdB1, e.b1);
                chk({n, ".B2"}, rdB2, e.b2);
            end
        end
    end

    // Drive one cycle of inputs and schedule the response expected after the next edge.
    task automatic drive(input string nm, input logic rst, input logic ireq,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic eb, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] b1, input logic [31:0] b2);
        exp_t e;
        @(negedge clock);
        #2;
        reset     = rst;
        init_req  = ireq;
        readReg1  = r1;
        readReg2  = r2;
        regWrite  = we;
        writeReg  = wr;
        writeData = wd;
        e.due = cyc + 1;
        e.expBusy = eb;
        e.a1 = a1; e.a2 = a2; e.b1 = b1; e.b2 = b2;
        expQ.push_back(e);
        nameQ.push_back(nm);
    endtask

    // Idle sweep of 32 edges with port writes to reg 9 that must be ignored.
    task automatic sweep(input string nm);
        for (int i = 1; i <= 32; i++) begin
            drive($sformatf("%s[%0d]", nm, i), 1'b0, 1'b0, 5'd9, 5'd7, 1'b1, 5'd9, 32'h55,
                  (i < 32), 32'h0, 32'h0, 32'h0, 32'h0);
        end
    endtask

    initial begin
        // Reset held: outputs zero, busy high.
        drive("rst0", 1'b1, 1'b0, 5'd7, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 0, 0, 0, 0);
        drive("rst1", 1'b1, 1'b0, 5'd7, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 0, 0, 0, 0);
        // Release reset: 32-cycle sweep, writes during it ignored.
        sweep("sweep0");
        drive("rd7_9", 1'b0, 1'b0, 5'd7, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 7, 9, 7, 9);
        // Write reg 5 while reading it: bypass vs read-before-write.
        drive("byp5", 1'b0, 1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0,
              32'hDEADBEEF, 32'hDEADBEEF, 5, 5);
        drive("rd5_0", 1'b0, 1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0,
              32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
        // Write reg 0: dropped with zero reg, ordinary otherwise.
        drive("wr0", 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 0, 0, 0, 0);
        drive("rd0", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 0, 0, 32'h1234, 32'h1234);
        // Reg 3 = 0xAAAA, then init_req with a concurrent write to reg 9.
        drive("wr3", 1'b0, 1'b0, 5'd3, 5'd3, 1'b1, 5'd3, 32'hAAAA, 1'b0,
              32'hAAAA, 32'hAAAA, 3, 3);
        drive("ireq", 1'b0, 1'b1, 5'd3, 5'd9, 1'b1, 5'd9, 32'h77, 1'b1,
              32'hAAAA, 32'h77, 32'hAAAA, 9);
        sweep("sweep1");
        drive("rd3_9", 1'b0, 1'b0, 5'd3, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 3, 9, 3, 9);
        // Re-init, reset at sweep cycle 10, full sweep redone.
        drive("ireq2", 1'b0, 1'b1, 5'd3, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 3, 9, 3, 9);
        for (int i = 1; i <= 9; i++) begin
            drive($sformatf("part[%0d]", i), 1'b0, 1'b0, 5'd9, 5'd7, 1'b0, 5'd0, 32'h0,
                  1'b1, 0, 0, 0, 0);
        end
        drive("midrst", 1'b1, 1'b0, 5'd9, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 0, 0, 0, 0);
        sweep("sweep2");
        drive("rd31_9", 1'b0, 1'b0, 5'd31, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 31, 9, 31, 9);
        drive("idle", 1'b0, 1'b0, 5'd0, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 0, 5, 0, 5);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clock);
        @(negedge clock);
        if (expQ.size() > 0) begin
            nTests++;
            nFail++;
            $display("FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
